// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: default widths, reset PC,
// NOP encoding and the buffering depth used by both fetch FIFOs.
package if_fetch_stage_pkg;

  localparam int          XLEN_DEFAULT         = 64;
  localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam int          QUEUE_DEPTH          = 2;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/adder.sv
// Plain combinational adder, wrap-around modulo 2^WIDTH.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/if_fetch_stage_fetch_queue.sv
// Two-entry synchronous FIFO with flush; head is a register so the consumer
// sees data one cycle after the push. Push while full is legal only with a pop.
module fetch_queue
  import if_fetch_stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry_reg [QUEUE_DEPTH];
  logic [1:0]       count_reg;
  logic             do_pop;
  logic             do_push;
  logic             wr_sel;

  assign do_pop  = pop && (count_reg != 2'd0);
  assign do_push = push && ((count_reg != 2'd2) || do_pop);
  // Slot 1 is written only when an entry stays behind the head after this cycle.
  assign wr_sel  = (count_reg == 2'd2) || ((count_reg == 2'd1) && !do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_reg <= 2'd0;
    end else begin
      if (do_pop) begin
        entry_reg[0] <= entry_reg[1];
      end
      if (do_push) begin
        entry_reg[wr_sel] <= push_data;
      end
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = entry_reg[0];
  assign count = count_reg;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC sequencing, in-order fetch issue with a 2-deep
// response buffer, redirect flush with stale-response dropping.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            if_exc_misaligned
);

  localparam int              IQ_W    = XLEN + 33;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_plus4;
  logic [1:0]      outstanding_reg;
  logic [1:0]      drop_cnt_reg;
  logic            idle_reg;
  logic            exc_pending_reg;

  logic            req_fire;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            rsp_cnt;
  logic            exc_push;
  logic            iq_push;
  logic            iq_pop;
  logic [IQ_W-1:0] iq_push_data;
  logic [IQ_W-1:0] iq_head;
  logic [1:0]      iq_count;
  logic [XLEN-1:0] pcq_head;
  logic [1:0]      pcq_count;
  logic [2:0]      inflight;

  adder #(.WIDTH(XLEN)) u_pc_inc (
    .a   (pc_reg),
    .b   (PC_STEP),
    .sum (pc_plus4)
  );

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop_cnt_reg != 2'd0);
  assign rsp_keep = imem_rsp_valid && (drop_cnt_reg == 2'd0) && (pcq_count != 2'd0);
  assign rsp_cnt  = rsp_keep || rsp_drop;
  assign iq_pop   = if_valid && if_ready;

  // Counting this cycle's pop as a free slot keeps 1 instr/cycle with 1-cycle memory
  // while still guaranteeing every response a queue slot.
  assign inflight = {1'b0, outstanding_reg} + {1'b0, iq_count} - {2'b00, iq_pop};

  assign imem_req_valid = !rst && !redirect_valid && !idle_reg && (inflight < 3'd2);
  assign imem_req_addr  = {pc_reg[XLEN-1:2], 2'b00};

  // A misaligned target is reported only after stale responses drain and decode is empty.
  assign exc_push = exc_pending_reg && (drop_cnt_reg == 2'd0) && (iq_count == 2'd0)
                    && !redirect_valid;
  assign iq_push  = rsp_keep || exc_push;
  assign iq_push_data = exc_push ? {pc_reg, NOP_INSTR, 1'b1}
                                 : {pcq_head, imem_rsp_data, 1'b0};

  fetch_queue #(.WIDTH(XLEN)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (pc_reg),
    .pop       (rsp_keep),
    .head      (pcq_head),
    .count     (pcq_count)
  );

  fetch_queue #(.WIDTH(IQ_W)) u_instr_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (iq_push),
    .push_data (iq_push_data),
    .pop       (iq_pop),
    .head      (iq_head),
    .count     (iq_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_VECTOR;
      outstanding_reg <= 2'd0;
      drop_cnt_reg    <= 2'd0;
      idle_reg        <= 1'b0;
      exc_pending_reg <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_reg + {1'b0, req_fire} - {1'b0, rsp_cnt};
      if (redirect_valid) begin
        pc_reg          <= redirect_pc;
        drop_cnt_reg    <= outstanding_reg - {1'b0, rsp_cnt};
        idle_reg        <= is_misaligned(redirect_pc[1:0]);
        exc_pending_reg <= is_misaligned(redirect_pc[1:0]);
      end else begin
        if (req_fire) begin
          pc_reg <= pc_plus4;
        end
        if (rsp_drop) begin
          drop_cnt_reg <= drop_cnt_reg - 2'd1;
        end
        if (exc_push) begin
          exc_pending_reg <= 1'b0;
        end
      end
    end
  end

  assign if_valid          = !rst && (iq_count != 2'd0);
  assign if_pc             = iq_head[IQ_W-1:33];
  assign if_instr          = iq_head[32:1];
  assign if_exc_misaligned = if_valid && iq_head[0];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with an in-order, variable-latency memory model.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_exc_misaligned;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] addr;
    int unsigned due;
  } mreq_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc;
  } deliv_t;

  mreq_t       mem_q[$];
  deliv_t      got[$];
  int unsigned mcyc  = 0;
  int unsigned lat   = 1;
  int unsigned fires = 0;

  if_fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .if_valid          (if_valid),
    .if_ready          (if_ready),
    .if_pc             (if_pc),
    .if_instr          (if_instr),
    .if_exc_misaligned (if_exc_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check_stream(input string tag, input logic [63:0] base, input int n_min);
    check({tag, "_cnt"}, 64'(got.size() >= n_min), 64'd1);
    for (int i = 0; i < got.size(); i++) begin
      logic [63:0] exp_pc;
      exp_pc = base + 64'(4 * i);
      check($sformatf("%s_pc%0d", tag, i), got[i].pc, exp_pc);
      check($sformatf("%s_instr%0d", tag, i), 64'(got[i].instr), 64'(mem_word(exp_pc)));
      check($sformatf("%s_exc%0d", tag, i), 64'(got[i].exc), 64'd0);
    end
  endtask

  // In-order memory: accepts at the edge, answers lat cycles later, cleared by rst.
  always @(posedge clk) begin
    logic        fire_s;
    logic        took_s;
    logic        rst_s;
    logic [63:0] addr_s;
    mcyc++;
    fire_s = imem_req_valid && imem_req_ready;
    took_s = imem_rsp_valid;
    rst_s  = rst;
    addr_s = imem_req_addr;
    #1;
    if (rst_s) begin
      mem_q.delete();
    end else begin
      if (took_s) void'(mem_q.pop_front());
      if (fire_s) begin
        mem_q.push_back('{addr_s, mcyc + lat});
        fires++;
      end
    end
    if (mem_q.size() > 0 && mem_q[0].due <= mcyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  always @(negedge clk) begin
    if (!rst && if_valid && if_ready) begin
      got.push_back('{if_pc, if_instr, if_exc_misaligned});
      $display("deliver pc=%h instr=%h exc=%0d", if_pc, if_instr, if_exc_misaligned);
    end
  end

  initial begin
    int base_fires;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0;
    imem_req_ready = 1'b1; if_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    step(); step();
    mid();
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_exc", 64'(if_exc_misaligned), 64'd0);
    step();

    // Reset release, streaming at 1 instr/cycle from cycle 3
    rst = 1'b0; got.delete();
    for (int c = 1; c <= 10; c++) begin
      mid();
      if (c == 1) check("t1_first_addr", imem_req_addr, 64'h8000_0000);
      if (c == 2) check("t1_second_addr", imem_req_addr, 64'h8000_0004);
      check($sformatf("t1_valid_c%0d", c), 64'(if_valid), 64'(c >= 3));
      step();
    end
    check("t1_total", 64'(got.size()), 64'd8);
    check_stream("t1", 64'h8000_0000, 8);

    // Decode stall: buffer fills to 2, issue stops, nothing lost on release
    if_ready = 1'b0; got.delete();
    for (int c = 11; c <= 15; c++) begin
      mid();
      check($sformatf("t2_req_off_c%0d", c), 64'(imem_req_valid), 64'd0);
      check($sformatf("t2_hold_c%0d", c), 64'(if_valid), 64'd1);
      step();
    end
    if_ready = 1'b1;
    repeat (10) step();
    check("t2_total", 64'(got.size()), 64'd10);
    check_stream("t2", 64'h8000_0020, 10);

    // Redirect with two requests outstanding on 3-cycle memory
    lat = 3;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    mid();
    check("t3_outstanding", 64'(mem_q.size()), 64'd2);
    check("t3_no_rsp", 64'(imem_rsp_valid), 64'd0);
    step();
    redirect_valid = 1'b0; got.delete();
    mid();
    check("t3_flush", 64'(if_valid), 64'd0);
    repeat (16) step();
    check_stream("t3", 64'h8000_0100, 3);

    // Redirect colliding with a response and a decode pop
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    step();
    redirect_valid = 1'b0;
    repeat (10) step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
    mid();
    check("t4_pre_rsp", 64'(imem_rsp_valid), 64'd1);
    check("t4_pre_valid", 64'(if_valid), 64'd1);
    step();
    redirect_valid = 1'b0; got.delete();
    mid();
    check("t4_n1_valid", 64'(if_valid), 64'd0);
    check("t4_n1_req", 64'(imem_req_valid), 64'd1);
    check("t4_n1_addr", imem_req_addr, 64'h8000_0300);
    step();
    mid();
    check("t4_n2_valid", 64'(if_valid), 64'd0);
    step();
    mid();
    check("t4_n3_valid", 64'(if_valid), 64'd1);
    check("t4_n3_pc", if_pc, 64'h8000_0300);
    step();
    repeat (5) step();
    check("t4_total", 64'(got.size()), 64'd6);
    check_stream("t4", 64'h8000_0300, 6);

    // Misaligned target: single exception entry, no memory traffic
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
    step();
    redirect_valid = 1'b0; got.delete(); base_fires = fires;
    mid();
    check("t5_n1_valid", 64'(if_valid), 64'd0);
    check("t5_n1_req", 64'(imem_req_valid), 64'd0);
    step();
    mid();
    check("t5_valid", 64'(if_valid), 64'd1);
    check("t5_exc", 64'(if_exc_misaligned), 64'd1);
    check("t5_pc", if_pc, 64'h8000_0102);
    check("t5_instr", 64'(if_instr), 64'h0000_0013);
    step();
    mid();
    check("t5_after_valid", 64'(if_valid), 64'd0);
    check("t5_after_req", 64'(imem_req_valid), 64'd0);
    step();
    repeat (5) step();
    check("t5_no_fetch", 64'(fires), 64'(base_fires));
    check("t5_single", 64'(got.size()), 64'd1);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0; got.delete();
    mid();
    check("t6_req_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t6_req_top_v", 64'(imem_req_valid), 64'd1);
    step();
    mid();
    check("t6_req_wrap", imem_req_addr, 64'h0);
    check("t6_req_wrap_v", 64'(imem_req_valid), 64'd1);
    step();
    repeat (6) step();
    check_stream("t6", 64'hFFFF_FFFF_FFFF_FFFC, 3);

    // Reset with two requests outstanding
    lat = 3;
    step(); step();
    mid();
    check("t7_outstanding", 64'(mem_q.size()), 64'd2);
    step();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      mid();
      check($sformatf("t7_rst_req%0d", c), 64'(imem_req_valid), 64'd0);
      check($sformatf("t7_rst_valid%0d", c), 64'(if_valid), 64'd0);
      check($sformatf("t7_rst_exc%0d", c), 64'(if_exc_misaligned), 64'd0);
      step();
    end
    rst = 1'b0; lat = 1; got.delete();
    mid();
    check("t7_first_req", 64'(imem_req_valid), 64'd1);
    check("t7_first_addr", imem_req_addr, 64'h8000_0000);
    check("t7_first_valid", 64'(if_valid), 64'd0);
    step();
    repeat (5) step();
    check("t7_total", 64'(got.size()), 64'd4);
    check_stream("t7", 64'h8000_0000, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
